// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its serializer.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] LF_CHAR = 8'h0A;

    // Zero bits above the real requester count make a modulo-8 scan equal a modulo-N scan.
    function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] start_idx);
        logic [7:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start_idx + 3'(i);
            if (!found && valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit, ClksPerBit cycles each.
module uart_tx_serializer
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned ClksPerBit = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              tx_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);

    uart_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              bit_end;

    assign bit_end = (cnt_q == CntW'(ClksPerBit - 1));
    assign busy_o  = (state_q != StIdle);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_o  = 1'b0;
        tx_o    = 1'b1;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = StStart;
                    shift_d = data_i;
                    bit_d   = '0;
                end
            end
            StStart: begin
                tx_o = 1'b0;
                if (bit_end) state_d = StData;
            end
            StData: begin
                tx_o = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) state_d = StStop;
                    else bit_d = bit_q + 3'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_o  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, line-locking arbiter that shares one 8N1 UART transmit line between requesters.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 256_000,
    parameter int unsigned MAX_BURST   = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o,
    output logic                   uart_tx_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned IDX_W        = $clog2(NUM_REQ);

    if (CLKS_PER_BIT < 2 || NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255)
    begin : g_param_check
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    logic             lock_q, lock_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             rr_seen_q, rr_seen_d;
    logic [7:0]       burst_q, burst_d;
    logic             lf_q, lf_d;

    logic               ser_busy, ser_done;
    logic               owner_valid, keep, lock_live, accept;
    logic [2:0]         scan_start;
    logic [7:0]         valid_ext, pick_all;
    logic [NUM_REQ-1:0] win, owner_oh;
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_data;
    logic               unused_pick;

    assign owner_valid = req_valid_i[rr_q];
    assign keep        = lock_q && owner_valid && (burst_q < 8'(MAX_BURST));
    // An idle owner that dropped valid loses the lock in this very cycle.
    assign lock_live   = lock_q && (ser_busy || owner_valid);
    assign valid_ext   = 8'(req_valid_i);
    assign pick_all    = rr_pick(valid_ext, scan_start);
    assign unused_pick = ^pick_all;

    // rr_q always names the last winner, so the scan resumes just past it; reset starts at 0.
    always_comb begin
        scan_start = 3'd0;
        if (rr_seen_q && rr_q != IDX_W'(NUM_REQ - 1)) scan_start = 3'(rr_q) + 3'd1;
    end

    always_comb begin
        win      = '0;
        owner_oh = '0;
        win_idx  = '0;
        win_data = '0;
        owner_oh[rr_q] = 1'b1;
        if (!ser_busy) begin
            if (keep) win = owner_oh;
            else win = pick_all[NUM_REQ-1:0];
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win[k]) begin
                win_idx  = IDX_W'(k);
                win_data = req_data_i[8*k +: 8];
            end
        end
    end

    assign accept      = |win;
    assign req_ready_o = win;
    assign grant_o     = win | (lock_live ? owner_oh : '0);
    assign busy_o      = ser_busy;

    always_comb begin
        lock_d    = lock_q;
        rr_d      = rr_q;
        rr_seen_d = rr_seen_q;
        burst_d   = burst_q;
        lf_d      = lf_q;
        if (accept) begin
            lock_d    = 1'b1;
            rr_d      = win_idx;
            rr_seen_d = 1'b1;
            burst_d   = keep ? burst_q + 8'd1 : 8'd1;
            lf_d      = (win_data == LF_CHAR);
        end else if (!ser_busy && lock_q && !owner_valid) begin
            lock_d  = 1'b0;
            burst_d = '0;
        end
        if (ser_done && (lf_q || burst_q == 8'(MAX_BURST))) begin
            lock_d  = 1'b0;
            burst_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q    <= 1'b0;
            rr_q      <= '0;
            rr_seen_q <= 1'b0;
            burst_q   <= '0;
            lf_q      <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            rr_q      <= rr_d;
            rr_seen_q <= rr_seen_d;
            burst_q   <= burst_d;
            lf_q      <= lf_d;
        end
    end

    uart_tx_serializer #(
        .ClksPerBit(CLKS_PER_BIT)
    ) u_serializer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(accept),
        .data_i (win_data),
        .busy_o (ser_busy),
        .done_o (ser_done),
        .tx_o   (uart_tx_o)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: main instance with MAX_BURST=4, second instance with MAX_BURST=1 for rotation.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid, req_ready, req_grant;
    logic [NR*8-1:0] req_data;
    logic          busy, tx;
    logic [NR-1:0] rr_valid, rr_ready, rr_grant;
    logic [NR*8-1:0] rr_data;
    logic          rr_busy, rr_tx;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .MAX_BURST(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .grant_o(req_grant), .busy_o(busy), .uart_tx_o(tx)
    );

    uart_tx_arbiter #(
        .NUM_REQ(NR), .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .MAX_BURST(1)
    ) dut_rr (
        .clk_i(clk), .rst_i(rst), .req_valid_i(rr_valid), .req_data_i(rr_data),
        .req_ready_o(rr_ready), .grant_o(rr_grant), .busy_o(rr_busy), .uart_tx_o(rr_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [7:0]    pend [NR][8];
    int            pcnt [NR];
    int            pidx [NR];
    int            acc_idx [16];
    logic [NR-1:0] acc_grant [16];
    int            acc_cyc [16];
    int            acc_n;
    logic [7:0]    mon_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic clear_all();
        for (int k = 0; k < NR; k++) begin
            pcnt[k] = 0;
            pidx[k] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            acc_idx[i]   = -1;
            acc_grant[i] = '0;
            acc_cyc[i]   = 0;
        end
        acc_n = 0;
        mon_q.delete();
    endtask

    task automatic load(input int k, input logic [7:0] b);
        pend[k][pcnt[k]] = b;
        pcnt[k]++;
    endtask

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int k = 0; k < NR; k++) if (pidx[k] < pcnt[k]) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            req_valid[k]        = (pidx[k] < pcnt[k]);
            req_data[8*k +: 8]  = (pidx[k] < pcnt[k]) ? pend[k][pidx[k]] : 8'h00;
        end
    endtask

    // Present each requester's queue, log every accept (index, grant, cycle) until all drained.
    task automatic run(input string tag, input int budget);
        int n = 0;
        drive();
        while (any_pending() && n < budget) begin
            #1;
            for (int k = 0; k < NR; k++) begin
                if (req_ready[k] && acc_n < 16) begin
                    acc_idx[acc_n]   = k;
                    acc_grant[acc_n] = req_grant;
                    acc_cyc[acc_n]   = cyc;
                    acc_n++;
                    pidx[k]++;
                end
            end
            tick();
            drive();
            n++;
        end
        chk({tag, "_drained"}, 32'(any_pending()), 32'd0);
    endtask

    // Mid-bit UART receiver on the main instance's line.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (5) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = tx;
                end
                repeat (10) @(negedge clk);
                if (tx === 1'b1) mon_q.push_back(b);
            end
        end
    end

    initial begin : stim
        int t;
        int got;
        int exp_rr [5];
        req_valid = '0;
        req_data  = '0;
        rr_valid  = '0;
        rr_data   = '0;
        clear_all();
        repeat (3) tick();

        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_grant", 32'(req_grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single byte 0x55 from req0
        load(0, 8'h55);
        run("t1", 20);
        t = acc_cyc[0];
        chk("t1_winner", 32'(acc_idx[0]), 32'd0);
        chk("t1_grant", 32'(acc_grant[0]), 32'b0001);
        wait_cyc(t + 1);
        chk("t1_start_low", 32'(tx), 32'd0);
        chk("t1_busy_rise", 32'(busy), 32'd1);
        wait_cyc(t + 10);
        chk("t1_start_end", 32'(tx), 32'd0);
        wait_cyc(t + 11);
        chk("t1_bit0", 32'(tx), 32'd1);
        wait_cyc(t + 21);
        chk("t1_bit1", 32'(tx), 32'd0);
        wait_cyc(t + 50);
        req_valid[1]    = 1'b1;
        req_data[15:8]  = 8'hEE;
        #1;
        chk("t1_no_ready_busy", 32'(req_ready), 32'd0);
        req_valid[1] = 1'b0;
        wait_cyc(t + 91);
        chk("t1_stop_high", 32'(tx), 32'd1);
        wait_cyc(t + 100);
        chk("t1_busy_last", 32'(busy), 32'd1);
        wait_cyc(t + 101);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        chk("t1_mon_byte", 32'(mon_q.size() > 0 ? mon_q[0] : 8'hXX), 32'h55);
        wait_cyc(t + 230);
        chk("t1_withdrawn_not_sent", 32'(mon_q.size()), 32'd1);

        // Line lock: "AB\n" from req0 before "Z" from req1
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_all();
        load(0, 8'h41);
        load(0, 8'h42);
        load(0, 8'h0A);
        load(1, 8'h5A);
        run("t2", 600);
        chk("t2_w0", 32'(acc_idx[0]), 32'd0);
        chk("t2_w1", 32'(acc_idx[1]), 32'd0);
        chk("t2_w2", 32'(acc_idx[2]), 32'd0);
        chk("t2_w3", 32'(acc_idx[3]), 32'd1);
        chk("t2_g0", 32'(acc_grant[0]), 32'b0001);
        chk("t2_g2", 32'(acc_grant[2]), 32'b0001);
        chk("t2_g3", 32'(acc_grant[3]), 32'b0010);
        chk("t2_gap_locked", 32'(acc_cyc[1] - acc_cyc[0]), 32'd101);
        chk("t2_gap_lf", 32'(acc_cyc[3] - acc_cyc[2]), 32'd101);
        wait_cyc(acc_cyc[3] + 50);
        chk("t2_grant_mid_z", 32'(req_grant), 32'b0010);
        wait_cyc(acc_cyc[3] + 102);
        chk("t2_mon_count", 32'(mon_q.size()), 32'd4);
        if (mon_q.size() == 4) begin
            chk("t2_mon_A", 32'(mon_q[0]), 32'h41);
            chk("t2_mon_B", 32'(mon_q[1]), 32'h42);
            chk("t2_mon_LF", 32'(mon_q[2]), 32'h0A);
            chk("t2_mon_Z", 32'(mon_q[3]), 32'h5A);
        end

        // Round-robin with MAX_BURST=1, all four always valid
        exp_rr = '{0, 1, 2, 3, 0};
        got = 0;
        rr_data  = 32'h34333231;
        rr_valid = 4'hF;
        for (int n = 0; n < 700 && got < 5; n++) begin
            #1;
            for (int k = 0; k < NR; k++) begin
                if (rr_ready[k] && got < 5) begin
                    chk($sformatf("t3_order%0d", got), 32'(k), 32'(exp_rr[got]));
                    got++;
                end
            end
            tick();
        end
        rr_valid = '0;
        chk("t3_count", 32'(got), 32'd5);

        // Burst limit: req2 streams six bytes while req3 waits with one
        clear_all();
        for (int i = 0; i < 6; i++) load(2, 8'h61 + 8'(i));
        load(3, 8'h7A);
        run("t4", 1200);
        chk("t4_w0", 32'(acc_idx[0]), 32'd2);
        chk("t4_w3", 32'(acc_idx[3]), 32'd2);
        chk("t4_w4", 32'(acc_idx[4]), 32'd3);
        chk("t4_w5", 32'(acc_idx[5]), 32'd2);
        chk("t4_w6", 32'(acc_idx[6]), 32'd2);
        chk("t4_gap_rotate", 32'(acc_cyc[4] - acc_cyc[3]), 32'd101);
        chk("t4_gap_resume", 32'(acc_cyc[5] - acc_cyc[4]), 32'd101);
        wait_cyc(acc_cyc[6] + 102);
        chk("t4_mon_count", 32'(mon_q.size()), 32'd7);
        if (mon_q.size() == 7) begin
            chk("t4_mon_d", 32'(mon_q[3]), 32'h64);
            chk("t4_mon_z", 32'(mon_q[4]), 32'h7A);
            chk("t4_mon_e", 32'(mon_q[5]), 32'h65);
        end

        // Owner drops valid: lock released and req3 served in the same idle cycle
        clear_all();
        load(1, 8'h78);
        run("t5a", 300);
        chk("t5_x_winner", 32'(acc_idx[0]), 32'd1);
        chk("t5_grant_locked", 32'(req_grant), 32'b0010);
        load(3, 8'h79);
        run("t5b", 300);
        chk("t5_y_winner", 32'(acc_idx[1]), 32'd3);
        chk("t5_y_grant", 32'(acc_grant[1]), 32'b1000);
        chk("t5_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd101);

        // Reset during data bit 3
        wait_cyc(acc_cyc[1] + 102);
        clear_all();
        load(0, 8'h00);
        run("t6a", 50);
        t = acc_cyc[0];
        wait_cyc(t + 45);
        chk("t6_bit3_low", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_tx_forced", 32'(tx), 32'd1);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("t6_busy_after", 32'(busy), 32'd0);
        chk("t6_grant_after", 32'(req_grant), 32'd0);
        repeat (120) tick();
        clear_all();
        load(2, 8'hA5);
        load(3, 8'h3C);
        run("t6b", 400);
        chk("t6_first", 32'(acc_idx[0]), 32'd2);
        chk("t6_first_grant", 32'(acc_grant[0]), 32'b0100);
        chk("t6_second", 32'(acc_idx[1]), 32'd3);
        wait_cyc(acc_cyc[1] + 102);
        chk("t6_mon_count", 32'(mon_q.size()), 32'd2);
        if (mon_q.size() == 2) begin
            chk("t6_mon_a5", 32'(mon_q[0]), 32'hA5);
            chk("t6_mon_3c", 32'(mon_q[1]), 32'h3C);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
